// File: rtl/ttlc_pkg.sv
// Shared definitions for the TTLC one-bit sequencer: opcodes, FSM encoding,
// instruction field positions and the RR logic-unit helper.
package ttlc_pkg;

    localparam int INSN_W = 12;
    localparam int OPC_HI = 11;
    localparam int OPC_LO = 8;
    localparam int OPR_HI = 7;
    localparam int OPR_LO = 0;

    localparam logic [3:0] OP_NOPO = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_LDC  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_ANDC = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_ORC  = 4'h6;
    localparam logic [3:0] OP_XNOR = 4'h7;
    localparam logic [3:0] OP_STO  = 4'h8;
    localparam logic [3:0] OP_STOC = 4'h9;
    localparam logic [3:0] OP_IEN  = 4'hA;
    localparam logic [3:0] OP_OEN  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RTN  = 4'hD;
    localparam logic [3:0] OP_SKZ  = 4'hE;
    localparam logic [3:0] OP_NOPF = 4'hF;

    localparam logic [1:0] ST_HALT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;

    // Non-logic opcodes leave RR untouched.
    function automatic logic rr_logic(input logic [3:0] op, input logic rr, input logic d);
        logic r;
        case (op)
            OP_LD:   r = d;
            OP_LDC:  r = ~d;
            OP_AND:  r = rr & d;
            OP_ANDC: r = rr & ~d;
            OP_OR:   r = rr | d;
            OP_ORC:  r = rr | ~d;
            OP_XNOR: r = ~(rr ^ d);
            default: r = rr;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ttlc_seq_if.sv
// Program-memory fetch handshake and I/O-map bit bus of the sequencer.
interface ttlc_seq_if #(parameter int PC_W = 8) ();

    logic [PC_W-1:0] prog_addr;
    logic            prog_req;
    logic            prog_ack;
    logic [11:0]     prog_data;
    logic [7:0]      io_addr;
    logic            io_we;
    logic            io_wdata;
    logic            io_rdata;

    modport master (
        output prog_addr, prog_req, io_addr, io_we, io_wdata,
        input  prog_ack, prog_data, io_rdata
    );

    modport slave (
        input  prog_addr, prog_req, io_addr, io_we, io_wdata,
        output prog_ack, prog_data, io_rdata
    );

endinterface

// File: rtl/ttlc_rstack.sv
// Circular return stack: a push on a full stack overwrites the oldest entry,
// a pop on an empty stack leaves it empty.
module ttlc_rstack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW - 1){1'b0}}, 1'b1};

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] ptr_r;
    logic [AW:0]   cnt_r;
    logic [AW-1:0] ptr_m1_s;

    assign ptr_m1_s = ptr_r - PTR_ONE;
    assign top      = mem_r[ptr_m1_s];
    assign empty    = (cnt_r == {(AW + 1){1'b0}});

    // Write pointer, occupancy and storage update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {AW{1'b0}};
            cnt_r <= {(AW + 1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (push) begin
            mem_r[ptr_r] <= push_data;
            ptr_r        <= ptr_r + PTR_ONE;
            if (cnt_r != FULL_CNT) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else if (pop && !empty) begin
            ptr_r <= ptr_m1_s;
            cnt_r <= cnt_r - CNT_ONE;
        end
    end

endmodule

// File: rtl/ttlc_seq.sv
// MC14500B-style one-bit sequencer: HALT/FETCH/EXEC control, RR logic unit,
// I/O enables, skip, and JMP/RTN through a circular return stack.
module ttlc_seq
    import ttlc_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int RS_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       step,
    ttlc_seq_if.master bus,
    output logic       rr,
    output logic       flag_o,
    output logic       flag_f,
    output logic       halted
);

    localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W - 1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0] PC_ZERO = {PC_W{1'b0}};

    logic [1:0]      state_r, state_s;
    logic [PC_W-1:0] pc_r, pc_s, pc_inc_s, jmp_tgt_s, rs_top_s;
    logic            rr_r, rr_s, ien_r, ien_s, oen_r, oen_s, skip_r, skip_s;
    logic [3:0]      ir_op_r, in_op_s;
    logic [7:0]      in_opr_s;
    logic            fetch_acc_s, exec_s, d_s, push_s, pop_s, rs_empty_s;
    logic            in_live_s, in_wr_s;
    logic [7:0]      io_addr_r;
    logic            io_we_r, io_wdata_r, flag_o_r, flag_f_r, prog_req_r, halted_r;

    assign in_op_s     = bus.prog_data[OPC_HI:OPC_LO];
    assign in_opr_s    = bus.prog_data[OPR_HI:OPR_LO];
    assign fetch_acc_s = (state_r == ST_FETCH) && bus.prog_ack;
    assign exec_s      = (state_r == ST_EXEC);
    assign d_s         = bus.io_rdata & ien_r;
    assign pc_inc_s    = pc_r + PC_ONE;
    assign jmp_tgt_s   = PC_W'(io_addr_r);
    // Write/flag outputs are decided while the instruction is accepted, so they
    // can be registered and still line up exactly with the EXEC cycle.
    assign in_live_s   = fetch_acc_s && !skip_r;
    assign in_wr_s     = in_live_s && oen_r && ((in_op_s == OP_STO) || (in_op_s == OP_STOC));

    ttlc_rstack #(.W(PC_W), .DEPTH(RS_DEPTH)) u_rstack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_inc_s),
        .top       (rs_top_s),
        .empty     (rs_empty_s)
    );

    // Control state transitions.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_HALT: begin
                if (run || step) state_s = ST_FETCH;
                else             state_s = ST_HALT;
            end
            ST_FETCH: begin
                if (bus.prog_ack) state_s = ST_EXEC;
                else              state_s = ST_FETCH;
            end
            ST_EXEC: begin
                if (run) state_s = ST_FETCH;
                else     state_s = ST_HALT;
            end
            default: state_s = ST_HALT;
        endcase
    end

    // Instruction execution: architectural next state produced in EXEC only.
    always_comb begin
        rr_s   = rr_r;
        ien_s  = ien_r;
        oen_s  = oen_r;
        skip_s = skip_r;
        pc_s   = pc_r;
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (exec_s) begin
            pc_s   = pc_inc_s;
            skip_s = 1'b0;
            if (!skip_r) begin
                rr_s = rr_logic(ir_op_r, rr_r, d_s);
                case (ir_op_r)
                    OP_IEN: ien_s = bus.io_rdata;
                    OP_OEN: oen_s = bus.io_rdata;
                    OP_JMP: begin
                        push_s = 1'b1;
                        pc_s   = jmp_tgt_s;
                    end
                    OP_RTN: begin
                        pop_s  = 1'b1;
                        pc_s   = rs_empty_s ? PC_ZERO : rs_top_s;
                        skip_s = 1'b1;
                    end
                    OP_SKZ:  skip_s = ~rr_r;
                    default: pc_s = pc_inc_s;
                endcase
            end else begin
                rr_s = rr_r;
            end
        end else begin
            pc_s = pc_r;
        end
    end

    // Architectural state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_HALT;
            pc_r    <= PC_ZERO;
            rr_r    <= 1'b0;
            ien_r   <= 1'b0;
            oen_r   <= 1'b0;
            skip_r  <= 1'b0;
            ir_op_r <= OP_NOPO;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            rr_r    <= rr_s;
            ien_r   <= ien_s;
            oen_r   <= oen_s;
            skip_r  <= skip_s;
            if (fetch_acc_s) begin
                ir_op_r <= in_op_s;
            end
        end
    end

    // Registered bus, flag and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_addr_r  <= 8'h00;
            io_we_r    <= 1'b0;
            io_wdata_r <= 1'b0;
            flag_o_r   <= 1'b0;
            flag_f_r   <= 1'b0;
            prog_req_r <= 1'b0;
            halted_r   <= 1'b1;
        end else begin
            prog_req_r <= (state_s == ST_FETCH);
            halted_r   <= (state_s == ST_HALT);
            io_we_r    <= in_wr_s;
            flag_o_r   <= in_live_s && (in_op_s == OP_NOPO);
            flag_f_r   <= in_live_s && (in_op_s == OP_NOPF);
            if (fetch_acc_s) begin
                io_addr_r <= in_opr_s;
            end
            if (in_wr_s) begin
                io_wdata_r <= (in_op_s == OP_STOC) ? ~rr_r : rr_r;
            end
        end
    end

    assign bus.prog_addr = pc_r;
    assign bus.prog_req  = prog_req_r;
    assign bus.io_addr   = io_addr_r;
    assign bus.io_we     = io_we_r;
    assign bus.io_wdata  = io_wdata_r;
    assign rr            = rr_r;
    assign flag_o        = flag_o_r;
    assign flag_f        = flag_f_r;
    assign halted        = halted_r;

endmodule

// File: tb/tb_ttlc_seq.sv
// Directed self-checking bench for ttlc_seq: program memory with adjustable
// acknowledge delay, a small I/O map, and logs of fetches, writes and flags.
module tb_ttlc_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic run = 1'b0;
    logic step = 1'b0;
    logic rr, flag_o, flag_f, halted;

    ttlc_seq_if #(.PC_W(8)) bus ();

    ttlc_seq #(.PC_W(8), .RS_DEPTH(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .step   (step),
        .bus    (bus),
        .rr     (rr),
        .flag_o (flag_o),
        .flag_f (flag_f),
        .halted (halted)
    );

    always #5 clk = ~clk;

    logic [11:0] prog_mem [256];
    logic        io_in    [256];
    int          ack_delay = 0;
    int          wcnt = 0;
    logic [7:0]  flog [128];
    int          fcnt = 0;
    int          wr_cnt [256];
    logic        last_wd [256];
    int          fo_cnt = 0;
    int          ff_cnt = 0;
    int          n_chk = 0;
    int          n_err = 0;

    assign bus.prog_ack  = bus.prog_req && (wcnt >= ack_delay);
    assign bus.prog_data = prog_mem[bus.prog_addr];
    assign bus.io_rdata  = (bus.io_addr == 8'h00) ? rr : io_in[bus.io_addr];

    always @(posedge clk) begin
        if (!bus.prog_req || bus.prog_ack) wcnt <= 0;
        else                               wcnt <= wcnt + 1;
        if (bus.prog_req && bus.prog_ack) begin
            if (fcnt < 128) flog[fcnt] <= bus.prog_addr;
            fcnt <= fcnt + 1;
        end
        if (bus.io_we) begin
            wr_cnt[bus.io_addr]  <= wr_cnt[bus.io_addr] + 1;
            last_wd[bus.io_addr] <= bus.io_wdata;
        end
        if (flag_o) fo_cnt <= fo_cnt + 1;
        if (flag_f) ff_cnt <= ff_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog_mem[i] = 12'h000;
    endtask

    task automatic do_reset();
        run   = 1'b0;
        step  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Run freely until the n-th instruction is being fetched, then drop run.
    task automatic run_n(input int n);
        int base;
        int t;
        base = fcnt;
        run  = 1'b1;
        t    = 0;
        while (!(bus.prog_req && fcnt == base + n - 1) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("run_timeout", (t < 2000) ? 32'd1 : 32'd0, 32'd1);
        run = 1'b0;
        t   = 0;
        while (!halted && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("halt_timeout", {31'd0, halted}, 32'd1);
        chk("exec_count", fcnt - base, n);
    endtask

    logic [7:0] exp_nest [16] = '{8'h00, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h51, 8'h52,
                                  8'h41, 8'h42, 8'h31, 8'h32, 8'h21, 8'h22, 8'h00, 8'h01};
    logic [7:0] exp_jmp [7] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h04, 8'h05};

    initial begin
        int b, w5, w6, w7, w9, fo0, ff0, t;
        for (int i = 0; i < 256; i++) begin
            io_in[i]   = 1'b0;
            wr_cnt[i]  = 0;
            last_wd[i] = 1'b0;
        end
        io_in[8'h40] = 1'b1;
        io_in[8'h41] = 1'b1;
        clear_prog();
        #2 rst_n = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_halted",  {31'd0, halted},       32'd1);
        chk("rst_req",     {31'd0, bus.prog_req}, 32'd0);
        chk("rst_we",      {31'd0, bus.io_we},    32'd0);
        chk("rst_ioaddr",  {24'd0, bus.io_addr},  32'h0);
        chk("rst_wdata",   {31'd0, bus.io_wdata}, 32'd0);
        chk("rst_rr",      {31'd0, rr},           32'd0);
        chk("rst_pc",      {24'd0, bus.prog_addr}, 32'h0);
        chk("rst_flags",   {30'd0, flag_o, flag_f}, 32'd0);

        // Reset-init: ORC 0; IEN 0; OEN 0; LD 40; STO 05; NOPO 33
        prog_mem[0] = 12'h600; prog_mem[1] = 12'hA00; prog_mem[2] = 12'hB00;
        prog_mem[3] = 12'h140; prog_mem[4] = 12'h805; prog_mem[5] = 12'h033;
        w5 = wr_cnt[5]; fo0 = fo_cnt;
        run_n(6);
        chk("init_wr05_cnt",  wr_cnt[5] - w5, 32'd1);
        chk("init_wr05_data", {31'd0, last_wd[5]}, 32'd1);
        chk("init_rr",        {31'd0, rr}, 32'd1);
        chk("init_flag_o",    fo_cnt - fo0, 32'd1);
        chk("init_ioaddr_hold", {24'd0, bus.io_addr}, 32'h33);
        chk("init_next_pc",   {24'd0, bus.prog_addr}, 32'h06);

        // OEN gating: oen=0 after reset, STO must not write
        do_reset(); clear_prog();
        prog_mem[0] = 12'h600; prog_mem[1] = 12'h805;
        w5 = wr_cnt[5];
        run_n(3);
        chk("oen0_no_write", wr_cnt[5] - w5, 32'd0);
        chk("oen0_rr",       {31'd0, rr}, 32'd1);

        // SKZ with RR=0: STO 06 skipped, STOC 07 writes 1
        do_reset(); clear_prog();
        prog_mem[0] = 12'hB41; prog_mem[1] = 12'hE00;
        prog_mem[2] = 12'h806; prog_mem[3] = 12'h907;
        w6 = wr_cnt[6]; w7 = wr_cnt[7];
        run_n(5);
        chk("skz0_wr06", wr_cnt[6] - w6, 32'd0);
        chk("skz0_wr07", wr_cnt[7] - w7, 32'd1);
        chk("skz0_d07",  {31'd0, last_wd[7]}, 32'd1);

        // SKZ with RR=1: both writes happen
        do_reset(); clear_prog();
        prog_mem[0] = 12'hB41; prog_mem[1] = 12'h600; prog_mem[2] = 12'hE00;
        prog_mem[3] = 12'h806; prog_mem[4] = 12'h907;
        w6 = wr_cnt[6]; w7 = wr_cnt[7];
        run_n(6);
        chk("skz1_wr06", wr_cnt[6] - w6, 32'd1);
        chk("skz1_d06",  {31'd0, last_wd[6]}, 32'd1);
        chk("skz1_wr07", wr_cnt[7] - w7, 32'd1);
        chk("skz1_d07",  {31'd0, last_wd[7]}, 32'd0);

        // JMP 10 at 03, RTN at 10: NOPF at 04 is skipped
        do_reset(); clear_prog();
        prog_mem[3] = 12'hC10; prog_mem[8'h10] = 12'hD00; prog_mem[4] = 12'hF00;
        b = fcnt; fo0 = fo_cnt; ff0 = ff_cnt;
        run_n(7);
        for (int i = 0; i < 7; i++) chk($sformatf("jmp_seq%0d", i), {24'd0, flog[b + i]}, {24'd0, exp_jmp[i]});
        chk("jmp_nopf_skipped", ff_cnt - ff0, 32'd0);
        chk("jmp_nopo_count",   fo_cnt - fo0, 32'd4);

        // Five nested JMPs then five RTNs: the fifth returns to 0
        do_reset(); clear_prog();
        prog_mem[8'h00] = 12'hC20; prog_mem[8'h20] = 12'hC30; prog_mem[8'h30] = 12'hC40;
        prog_mem[8'h40] = 12'hC50; prog_mem[8'h50] = 12'hC60; prog_mem[8'h60] = 12'hD00;
        prog_mem[8'h51] = 12'hF00; prog_mem[8'h52] = 12'hD00; prog_mem[8'h41] = 12'hF00;
        prog_mem[8'h42] = 12'hD00; prog_mem[8'h31] = 12'hF00; prog_mem[8'h32] = 12'hD00;
        prog_mem[8'h21] = 12'hF00; prog_mem[8'h22] = 12'hD00;
        b = fcnt; ff0 = ff_cnt;
        run_n(16);
        for (int i = 0; i < 16; i++) chk($sformatf("nest_seq%0d", i), {24'd0, flog[b + i]}, {24'd0, exp_nest[i]});
        chk("nest_nopf_skipped", ff_cnt - ff0, 32'd0);

        // PC wrap from FF to 00
        do_reset(); clear_prog();
        prog_mem[8'h00] = 12'hCFF;
        b = fcnt;
        run_n(3);
        chk("wrap_ff",  {24'd0, flog[b + 1]}, 32'hFF);
        chk("wrap_00",  {24'd0, flog[b + 2]}, 32'h00);

        // Single step with prog_ack delayed 3 cycles
        do_reset(); clear_prog();
        ack_delay = 3;
        b = fcnt; fo0 = fo_cnt;
        chk("step_pre_halted", {31'd0, halted}, 32'd1);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("step_req%0d", i),  {31'd0, bus.prog_req}, 32'd1);
            chk($sformatf("step_addr%0d", i), {24'd0, bus.prog_addr}, 32'h00);
            @(negedge clk);
        end
        chk("step_exec_flag", {31'd0, flag_o}, 32'd1);
        chk("step_exec_nohalt", {31'd0, halted}, 32'd0);
        @(negedge clk);
        chk("step_halted", {31'd0, halted}, 32'd1);
        repeat (5) @(negedge clk);
        chk("step_one_exec", fcnt - b, 32'd1);
        chk("step_flag_cnt", fo_cnt - fo0, 32'd1);
        chk("step_pc", {24'd0, bus.prog_addr}, 32'h01);
        chk("step_still_halted", {31'd0, halted}, 32'd1);
        ack_delay = 0;

        // Async reset during the EXEC cycle of a STO
        do_reset(); clear_prog();
        prog_mem[0] = 12'hB41; prog_mem[1] = 12'h600; prog_mem[2] = 12'h809;
        w9 = wr_cnt[9];
        run = 1'b1;
        t = 0;
        while (!bus.io_we && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ar_we_seen", {31'd0, bus.io_we}, 32'd1);
        chk("ar_we_addr", {24'd0, bus.io_addr}, 32'h09);
        chk("ar_we_data", {31'd0, bus.io_wdata}, 32'd1);
        #1 rst_n = 1'b0;
        run = 1'b0;
        #1;
        chk("ar_we_drop", {31'd0, bus.io_we},    32'd0);
        chk("ar_halted",  {31'd0, halted},       32'd1);
        chk("ar_req",     {31'd0, bus.prog_req}, 32'd0);
        chk("ar_rr",      {31'd0, rr},           32'd0);
        chk("ar_ioaddr",  {24'd0, bus.io_addr},  32'h00);
        chk("ar_wdata",   {31'd0, bus.io_wdata}, 32'd0);
        chk("ar_pc",      {24'd0, bus.prog_addr}, 32'h00);
        @(negedge clk);
        chk("ar_no_write", wr_cnt[9] - w9, 32'd0);
        run   = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_req",  {31'd0, bus.prog_req}, 32'd1);
        chk("rel_addr", {24'd0, bus.prog_addr}, 32'h00);
        run = 1'b0;
        repeat (4) @(negedge clk);
        chk("rel_halted", {31'd0, halted}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ttlc_seq.md
# ttlc_seq

MC14500B-style one-bit sequencer for the Tiny Tapeout Logic Controller. It fetches 12-bit instructions from a program-memory handshake port and executes them against the TTLC I/O map. It drives the I/O block's address, write strobe, write data and RR inputs, and consumes its combinational read bit. It adds run/step control and a small return stack.

## Interface

Parameters:
- `PC_W`, default 8: program counter width (program space 2^PC_W words).
- `RS_DEPTH`, default 4: return stack entries (power of 2).

Ports:
- `clk` in, 1: the only clock.
- `rst_n` in, 1: asynchronous, active-low reset.
- `run` in, 1: level; 1 means free-running execution.
- `step` in, 1: one-cycle pulse; executes exactly one instruction while `run`=0.
- `prog_addr` out, PC_W: instruction address (equals PC).
- `prog_req` out, 1: fetch request; held until acknowledged.
- `prog_ack` in, 1: instruction valid this cycle.
- `prog_data` in, 12: `[11:8]` opcode, `[7:0]` I/O operand address.
- `io_addr` out, 8: I/O map bit address.
- `io_we` out, 1: single-cycle write strobe.
- `io_wdata` out, 1: write bit.
- `io_rdata` in, 1: combinational read of bit `io_addr`.
- `rr` out, 1: result register; also read back by the I/O block at bit 0.
- `flag_o` out, 1: one-cycle pulse on NOPO.
- `flag_f` out, 1: one-cycle pulse on NOPF.
- `halted` out, 1: 1 in HALT state.

## Operation

Opcodes (MC14500B numbering). D = `io_rdata & ien`.
- 0 NOPO: pulse `flag_o`.
- 1 LD: RR=D. 2 LDC: RR=~D.
- 3 AND: RR&=D. 4 ANDC: RR&=~D.
- 5 OR: RR|=D. 6 ORC: RR|=~D.
- 7 XNOR: RR=~(RR^D).
- 8 STO: if oen, write RR. 9 STOC: if oen, write ~RR.
- A IEN: ien=`io_rdata`, ungated by ien. B OEN: oen=`io_rdata`, ungated.
- C JMP: push PC+1, then PC=operand[PC_W-1:0].
- D RTN: pop PC and set skip.
- E SKZ: if RR==0, set skip.
- F NOPF: pulse `flag_f`.

Skip:
- When skip is set, the next fetched instruction executes as a no-op: no state change, no `io_we`, no flag pulses.
- skip then clears.

Return stack (RS_DEPTH entries, circular):
- Push on a full stack overwrites the oldest entry.
- Pop on an empty stack returns 0 and leaves the stack empty.

PC:
- Increments modulo 2^PC_W after every instruction except JMP and RTN.
- 2^PC_W-1 wraps to 0.

State machine:
- HALT: `halted`=1. Goes to FETCH if `run`=1 or `step`=1.
- FETCH: `prog_req`=1. Goes to EXEC on `prog_ack`; otherwise stays.
- EXEC: one cycle.
  - `io_addr`=operand; `io_rdata` is sampled; RR/ien/oen/PC/skip/stack update at the clock edge.
  - STO/STOC with oen=1 assert `io_we` with `io_wdata`=RR or ~RR (pre-update value).
  - Next state is FETCH if `run`=1, else HALT.
- `run` falling during FETCH: the fetch completes and the instruction executes, then HALT.
- `step` is ignored outside HALT.
- In HALT and FETCH: `io_we`=0, `io_addr` holds the last operand.

Reset values (asynchronous on `rst_n`=0):
- PC=0, RR=0, ien=0, oen=0, skip=0, stack empty, state=HALT.
- `prog_req`=0, `io_we`=0, `io_addr`=0, `io_wdata`=0, flags=0, `halted`=1.
- Reset asserted mid-FETCH or mid-EXEC aborts immediately; no write completes.
- Releasing reset with `run`=1 starts fetching at PC 0 on the first clock after release.

## Timing

- Minimum 2 cycles per instruction: one FETCH cycle with same-cycle `prog_ack`, then one EXEC cycle. Each cycle of `prog_ack` delay adds one cycle.
- `prog_addr` is stable for the whole FETCH state.
- `io_addr` is valid throughout EXEC. The read is combinational within EXEC, so the I/O block's read path must settle in one cycle.
- `io_we` is high for exactly the EXEC cycle. The I/O block captures it on the edge that ends EXEC.
- RR visible on `rr` the cycle after EXEC. A STO immediately following an LD writes the new RR.
- Flag pulses coincide with the EXEC cycle.

## Structure

- Shared package `ttlc_pkg`:
  - opcode localparams (`OP_NOPO`..`OP_NOPF`)
  - state encoding (`ST_HALT`, `ST_FETCH`, `ST_EXEC`)
  - instruction field positions
- Sub-module `ttlc_rstack`: the circular return stack with push/pop/empty.
- Decode and datapath live in `ttlc_seq`.

## Test plan

- Reset-init sequence:
  - Program ORC 0; IEN 0; OEN 0; LD 0x40; STO 0x05.
  - I/O bit 0x40 forced to 1.
  - Required: `io_we` pulses once with `io_addr`=0x05, `io_wdata`=1. RR=1 thereafter.
- OEN gating:
  - With oen=0, STO 0x05.
  - Required: `io_we` stays 0 and RR is unchanged.
- SKZ:
  - RR=0, program SKZ; STO 0x06; STOC 0x07.
  - Required: only the write to 0x07 occurs, with `io_wdata`=1. Repeated with RR=1, both writes occur.
- JMP/RTN and wrap:
  - JMP 0x10 at PC 0x03, RTN at 0x10.
  - Required: execution resumes at 0x05 (0x04 skipped).
  - Five nested JMPs then five RTNs: the fifth RTN returns to PC 0.
  - PC 0xFF followed by NOPO: next `prog_addr` is 0x00.
- Handshake/step:
  - `prog_ack` delayed 3 cycles: `prog_req`/`prog_addr` held stable the whole time.
  - `run`=0 with one `step` pulse: exactly one EXEC, then `halted`=1.
- Async reset mid-EXEC of a STO: `io_we` drops immediately, and all outputs take their reset values.
